block_match_select: RTL
=======================

BLOCK_MATCH_SELECT -- requirements
Module: block_match_select

Interface
REQ-001 Parameter block_size, default 16: side length of the 1-bit-per-pixel block in pixels.
REQ-002 Parameter cost_w, default $clog2(block_size*block_size+1) (9): width of the match cost.
REQ-003 Port clk  in  1: single clock; all logic on rising edge.
REQ-004 Port reset  in  1: asynchronous, active-low (asserted at 0); one clock, async active-low reset.
REQ-005 Port blks_valid  in  1: candidate beat valid; one beat per cycle, no backpressure.
REQ-006 Port blk_block  in  block_size*block_size: reference block bits.
REQ-007 Port srch_block  in  block_size*block_size: candidate block bits.
REQ-008 Port coords_in  in  16: candidate {row[15:8], col[7:0]}.
REQ-009 Port blk_index_i  in  16: index of the block being matched, stable while the frame runs.
REQ-010 Port match_done  in  1: matcher idle level; a 0->1 transition ends the frame.
REQ-011 Port result_valid  out  1: best-match result available.
REQ-012 Port result_ready  in  1: consumer accepts the result.
REQ-013 Port best_coords  out  16: coords of the minimum-cost candidate.
REQ-014 Port best_cost  out  cost_w: minimum cost.
REQ-015 Port blk_index_o  out  16: blk_index_i captured with the frame.
REQ-016 Port beat_count  out  16: beats in the reported frame, saturating at 16'hFFFF.
REQ-017 Port overflow  out  1: sticky flag; a result was dropped.

Function
REQ-018 Cost per beat: popcount(blk_block XOR srch_block), range 0..block_size^2.
REQ-019 Stage S1 registers the per-row popcounts, coords, blk_index_i and end marker; stage S2 registers the summed cost; stage S3 updates the min/argmin registers.
REQ-020 Frame end: the registered match_done is 0 and match_done is 1 in the same cycle; it is tagged onto that cycle's beat, or onto an injected bubble when blks_valid=0.
REQ-021 A beat coincident with the frame-end edge belongs to the ending frame.
REQ-022 The first beat of a frame loads min unconditionally; later beats update only if cost < min (strict), so the earliest candidate wins a tie.
REQ-023 The end marker reaching S3 publishes {argmin, min, index, count} to the outputs in the next cycle (result_valid 4 cycles after the sampling edge of the last beat), then clears the frame state.
REQ-024 A frame with zero beats publishes nothing and does not set overflow.
REQ-025 result_valid holds, with outputs stable, until result_valid && result_ready; it then deasserts next cycle unless a new result loads.
REQ-026 A new result while result_valid=1 and result_ready=0: the new result is dropped, the old one is kept, and overflow is set.
REQ-027 A new result in the same cycle as an accepting handshake loads the new result, with no overflow.
REQ-028 A beat arriving after a frame end but before publish goes to the next frame; the pipeline is fully back-to-back.
REQ-029 match_done held high with no edge does nothing; blks_valid beats without a later edge accumulate indefinitely.

Reset
REQ-030 On reset=0, at once: result_valid=0, best_coords=0, best_cost=0, blk_index_o=0, beat_count=0, overflow=0, all pipeline valids and end markers 0, frame-started cleared, registered match_done=1 (no false edge after reset).
REQ-031 Reset mid-frame discards all partial state; deassertion is synchronized to clk by the integrating top level.

Verification
REQ-032 Identical blocks at coords 0x0003, all other beats cost 5, 48 beats, done edge after the last beat -> best_coords=0x0003, best_cost=0, beat_count=48.
REQ-033 Costs 7,4,4,9 at cols 0..3 with the done edge coincident with the col-3 beat -> best_coords=0x0001, best_cost=4, beat_count=4, result_valid 4 cycles after the last beat edge.
REQ-034 blk_block all ones, srch_block all zeros, single beat -> best_cost=256.
REQ-035 result_ready=0, two frames complete -> the first result is held and overflow=1; result_ready=1 -> the first result is accepted, then result_valid=0.
REQ-036 done edge with no beats in the frame -> no result_valid; reset=0 asserted mid-frame -> all outputs 0 next edge, and a new frame afterwards reports only its own beats.

Source files
------------

// File: rtl/block_match_select.sv
// Best-match selector: scores candidate blocks by Hamming distance to a reference block and
// reports the minimum-cost candidate of each frame through a valid/ready result port.
module block_match_select #(
  parameter int unsigned block_size = 16,
  parameter int unsigned cost_w     = $clog2(block_size * block_size + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             blks_valid,
  input  logic [block_size*block_size-1:0] blk_block,
  input  logic [block_size*block_size-1:0] srch_block,
  input  logic [15:0]                      coords_in,
  input  logic [15:0]                      blk_index_i,
  input  logic                             match_done,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic [15:0]                      best_coords,
  output logic [cost_w-1:0]                best_cost,
  output logic [15:0]                      blk_index_o,
  output logic [15:0]                      beat_count,
  output logic                             overflow
);

  localparam int unsigned RowW = $clog2(block_size + 1);

  // Input edge detect and per-row popcounts
  logic                                done_q;
  logic                                frame_end;
  logic [block_size*block_size-1:0]    diff;
  logic [block_size-1:0][RowW-1:0]     row_pc_d;

  assign frame_end = match_done & ~done_q;
  assign diff      = blk_block ^ srch_block;

  always_comb begin
    row_pc_d = '0;
    for (int r = 0; r < int'(block_size); r++) begin
      for (int c = 0; c < int'(block_size); c++) begin
        row_pc_d[r] = row_pc_d[r] + RowW'(diff[r * int'(block_size) + c]);
      end
    end
  end

  // S1: row popcounts, coords, index, end marker
  logic                            s1_beat_q, s1_end_q;
  logic [block_size-1:0][RowW-1:0] s1_row_pc_q;
  logic [15:0]                     s1_coords_q, s1_index_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q      <= 1'b1;
      s1_beat_q   <= 1'b0;
      s1_end_q    <= 1'b0;
      s1_row_pc_q <= '0;
      s1_coords_q <= '0;
      s1_index_q  <= '0;
    end else begin
      done_q    <= match_done;
      s1_beat_q <= blks_valid;
      s1_end_q  <= frame_end;
      if (blks_valid || frame_end) begin
        s1_row_pc_q <= row_pc_d;
        s1_coords_q <= coords_in;
        s1_index_q  <= blk_index_i;
      end
    end
  end

  // S2: summed cost
  logic [cost_w-1:0] cost_sum;
  logic              s2_beat_q, s2_end_q;
  logic [cost_w-1:0] s2_cost_q;
  logic [15:0]       s2_coords_q, s2_index_q;

  always_comb begin
    cost_sum = '0;
    for (int r = 0; r < int'(block_size); r++) begin
      cost_sum = cost_sum + cost_w'(s1_row_pc_q[r]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_beat_q   <= 1'b0;
      s2_end_q    <= 1'b0;
      s2_cost_q   <= '0;
      s2_coords_q <= '0;
      s2_index_q  <= '0;
    end else begin
      s2_beat_q <= s1_beat_q;
      s2_end_q  <= s1_end_q;
      if (s1_beat_q || s1_end_q) begin
        s2_cost_q   <= cost_sum;
        s2_coords_q <= s1_coords_q;
        s2_index_q  <= s1_index_q;
      end
    end
  end

  // S3: running min/argmin; the end marker trails the last update by one register
  logic              started_q, started_d;
  logic [cost_w-1:0] min_q, min_d;
  logic [15:0]       argmin_q, argmin_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       index_q, index_d;
  logic              s3_end_q;

  always_comb begin
    started_d = started_q;
    min_d     = min_q;
    argmin_d  = argmin_q;
    count_d   = count_q;
    index_d   = index_q;
    // A finished frame is snapshotted this cycle; a concurrent beat starts the next one
    if (s3_end_q) begin
      started_d = 1'b0;
      count_d   = '0;
    end
    if (s2_beat_q || s2_end_q) begin
      index_d = s2_index_q;
    end
    if (s2_beat_q) begin
      if (!started_d || (s2_cost_q < min_d)) begin
        min_d    = s2_cost_q;
        argmin_d = s2_coords_q;
      end
      started_d = 1'b1;
      if (count_d != 16'hFFFF) begin
        count_d = count_d + 16'd1;
      end
    end
  end

  // Publish staging, decoupled from the frame state that clears behind it
  logic              pend_valid_q;
  logic [15:0]       pend_coords_q, pend_index_q, pend_count_q;
  logic [cost_w-1:0] pend_cost_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q     <= 1'b0;
      min_q         <= '0;
      argmin_q      <= '0;
      count_q       <= '0;
      index_q       <= '0;
      s3_end_q      <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_coords_q <= '0;
      pend_cost_q   <= '0;
      pend_index_q  <= '0;
      pend_count_q  <= '0;
    end else begin
      started_q    <= started_d;
      min_q        <= min_d;
      argmin_q     <= argmin_d;
      count_q      <= count_d;
      index_q      <= index_d;
      s3_end_q     <= s2_end_q;
      pend_valid_q <= s3_end_q && (count_q != 16'd0);
      if (s3_end_q) begin
        pend_coords_q <= argmin_q;
        pend_cost_q   <= min_q;
        pend_index_q  <= index_q;
        pend_count_q  <= count_q;
      end
    end
  end

  // Result holding register with sticky drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_valid <= 1'b0;
      best_coords  <= '0;
      best_cost    <= '0;
      blk_index_o  <= '0;
      beat_count   <= '0;
      overflow     <= 1'b0;
    end else if (pend_valid_q) begin
      if (!result_valid || result_ready) begin
        result_valid <= 1'b1;
        best_coords  <= pend_coords_q;
        best_cost    <= pend_cost_q;
        blk_index_o  <= pend_index_q;
        beat_count   <= pend_count_q;
      end else begin
        overflow <= 1'b1;
      end
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule
